// File: rtl/alu_cmd_loader.sv
// Serial command loader for the 2-bit ALU / seven-segment block: 3-wire shift-in,
// double-buffered cmd word, optional operand sweep. Optional parity: ALU_CMD_PARITY_EN.
module alu_cmd_loader #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SWEEP_DIV   = 1000,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       sdi,
    input  logic       sweep,
    output logic [7:0] cmd,
    output logic       cmd_strobe,
    output logic       busy,
    output logic       par_err
);

`ifdef ALU_CMD_PARITY_EN
    localparam int unsigned FRAME_BITS = 9;
`else
    localparam int unsigned FRAME_BITS = 8;
`endif
    // The shift register never holds the final bit; it is taken straight from sdi.
    localparam int unsigned SH_W  = FRAME_BITS - 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT);
    localparam int unsigned DIV_W = $clog2(SWEEP_DIV);

    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWEEP_DIV - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   sclk_prev_q;

    logic [0:0]       state_q,  state_d;
    logic [3:0]       cnt_q,    cnt_d;
    logic [SH_W-1:0]  shreg_q,  shreg_d;
    logic [TO_W-1:0]  to_q,     to_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [7:0]       cmd_q,    cmd_d;
    logic             strobe_q;
    logic             par_err_q, par_err_d;

    logic       sclk_s;
    logic       sdi_s;
    logic       sample;
    logic       commit;
    logic       perr_set;
    logic [7:0] word;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];
    assign sample = sclk_s & ~sclk_prev_q;

`ifdef ALU_CMD_PARITY_EN
    assign word = shreg_q;
`else
    assign word = {shreg_q, sdi_s};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        to_d     = to_q;
        commit   = 1'b0;
        perr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                to_d = '0;
                if (sample) begin
                    shreg_d = {shreg_q[SH_W-2:0], sdi_s};
                    cnt_d   = 4'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sample) begin
                    to_d = '0;
                    if (cnt_q == LAST_BIT) begin
`ifdef ALU_CMD_PARITY_EN
                        if (^{shreg_q, sdi_s}) perr_set = 1'b1;
                        else                   commit   = 1'b1;
`else
                        commit = 1'b1;
`endif
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        shreg_d = {shreg_q[SH_W-2:0], sdi_s};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else if (to_q == TO_LAST) begin
                    to_d    = '0;
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                shreg_d = '0;
                to_d    = '0;
            end
        endcase
    end

    // A commit overrides a coincident sweep step and restarts the divider.
    always_comb begin
        div_d     = div_q;
        cmd_d     = cmd_q;
        par_err_d = par_err_q | perr_set;
        if (commit) begin
            div_d = '0;
            cmd_d = word;
        end else if (!sweep) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            cmd_d = {cmd_q[7:4] + 4'd1, cmd_q[3:0]};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            to_q        <= '0;
            div_q       <= '0;
            cmd_q       <= '0;
            strobe_q    <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            to_q        <= to_d;
            div_q       <= div_d;
            cmd_q       <= cmd_d;
            strobe_q    <= commit;
            par_err_q   <= par_err_d;
        end
    end

    assign cmd        = cmd_q;
    assign cmd_strobe = strobe_q;
    assign busy       = (state_q == ST_SHIFT);
`ifdef ALU_CMD_PARITY_EN
    assign par_err    = par_err_q;
`else
    assign par_err    = 1'b0;
`endif

endmodule

// File: doc/alu_cmd_loader.md
Name: alu_cmd_loader

Overview:
- Upstream input stage for the 2-bit ALU / seven-segment display block.
- Receives an 8-bit command word over a 3-wire serial link (sclk, sdi, async to clk).
- Holds the command word stable on cmd[7:0], which feeds the ALU block's 8-bit input bus directly.
- Optional sweep mode steps through all 16 operand combinations, so every ALU result can be shown without reloading.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the sclk/sdi synchronisers (min 2).
- SWEEP_DIV, 1000, clk cycles per sweep step (min 2).
- TIMEOUT, 4096, clk cycles without an sclk edge before a partial word is discarded (min 16).

Ports:
- clk  in  1  system clock; maps to io_in[0] at the wrapper.
- reset  in  1  asynchronous, active-high reset; maps to io_in[1] at the wrapper.
- sclk  in  1  serial clock, asynchronous; bits are taken on its rising edge after synchronisation.
- sdi  in  1  serial data, MSB first; synchronised with the same depth as sclk.
- sweep  in  1  level input; 1 = operand sweep enabled.
- cmd  out  8  command word to the ALU block: [0] operand-set select, [1] display enable, [3:2] function select, [5:4] operand A, [7:6] operand B.
- cmd_strobe  out  1  one-cycle pulse when cmd is updated by a serial commit.
- busy  out  1  high while a partial word is held (state SHIFT).
- par_err  out  1  sticky parity error flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (async assert, sync release on clk): cmd=8'h00, cmd_strobe=0, busy=0, par_err=0, bit counter=0, shift register=0, divider=0, timeout counter=0, state=IDLE.
- Synchronisers: sclk and sdi each pass through SYNC_STAGES flops. A rising edge of synchronised sclk gives a one-cycle sample pulse. sdi is taken from the same synchronised stage as sclk.
- FSM state IDLE: the bit counter is 0. On a sample pulse: shift sdi in, counter becomes 1, go to SHIFT.
- FSM state SHIFT: each sample pulse shifts in one bit and increments the counter.
  - On the 8th bit, cmd <= {shreg[6:0], sdi} on that same clk edge; cmd_strobe=1 for the following cycle only; counter clears; go to IDLE.
- Latency: pin-level sclk edge to cmd update is SYNC_STAGES+1 clk cycles.
- Timeout: in SHIFT, a counter runs on every cycle with no sample pulse and clears on each pulse. When it reaches TIMEOUT, the partial word is discarded, the counter clears and the FSM goes to IDLE. cmd is unchanged and no strobe is issued.
- busy = (state == SHIFT).
- cmd holds its value between commits. Shifting never disturbs cmd (double-buffered).
- Sweep: while sweep=1, the divider counts 0..SWEEP_DIV-1. At the wrap, cmd[7:4] <= cmd[7:4]+1 mod 16 (so 4'hF goes to 4'h0); cmd[3:0] is untouched. No cmd_strobe is issued for sweep steps.
  - When sweep=0, the divider is held at 0 and cmd is frozen.
- Commit and sweep step in the same cycle: the commit wins, the sweep step is dropped and the divider restarts at 0.
- Reset in mid-word: all state returns to reset values and the partial word is lost.

Optional Feature:
- Macro: ALU_CMD_PARITY_EN.
- Defined: the frame is 9 bits, 8 data bits MSB first followed by an even-parity bit.
  - 9th bit correct: commit exactly as above.
  - 9th bit wrong: no commit, no strobe, par_err set to 1 and held until reset. The FSM returns to IDLE either way.
- Not defined: 8-bit frames, no parity logic, par_err is constant 0.

Test Plan:
- Reset with all inputs 0 -> cmd=8'h00, cmd_strobe=0, busy=0; release reset with no activity for 10000 cycles -> cmd stays 8'h00.
- Shift 8'hA7 (bits 1,0,1,0,0,1,1,1) with sclk period 8 clk, sweep=0 -> busy high from 1st bit to 8th; cmd=8'hA7 SYNC_STAGES+1 cycles after 8th sclk edge; cmd_strobe high exactly 1 cycle.
- Shift 5 bits of 8'h3C, then idle TIMEOUT+10 cycles, then shift a full 8'h5A -> after timeout busy=0 and cmd unchanged; final cmd=8'h5A with exactly one strobe.
- Load 8'hF3, set sweep=1 for 3*SWEEP_DIV cycles -> cmd sequence 8'hF3, 8'h03, 8'h13, 8'h23; low nibble constant 4'h3; no strobes.
- Sweep active with the 8th bit of 8'h81 arriving on a divider wrap cycle -> cmd=8'h81 (no increment); next step at +SWEEP_DIV cycles gives 8'h91.
- ALU_CMD_PARITY_EN defined: send 8'h07 + parity 1 -> cmd=8'h07, par_err=0; send 8'h07 + parity 0 -> cmd stays 8'h07, no strobe, par_err=1 and stays 1 until reset.
